// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and 8N1 frame constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

  // 25 MHz system clock / 115200 baud
  localparam int unsigned ClkCountLimitDefault = 217;

  localparam int unsigned DataBits  = 8;
  localparam logic        StopLevel = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StClean = 3'd4,
    StBreak = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module uart_rx_sync #(
  parameter logic reset_value = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= reset_value;
      sync_q <= reset_value;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, one-cycle byte
// and framing-error strobes, and a held-low (break) detector.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clock_count_limit = ClkCountLimitDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_serial_pin,
  output logic [7:0] out_rx_byte,
  output logic       out_rx_data_valid,
  output logic       out_rx_active,
  output logic       out_framing_error
);

  localparam int unsigned half_count = (clock_count_limit - 1) / 2;
  localparam int unsigned CntW       = $clog2(clock_count_limit);

  localparam logic [CntW-1:0] CntHalf = CntW'(half_count);
  localparam logic [CntW-1:0] CntLast = CntW'(clock_count_limit - 1);
  localparam logic [2:0]      IdxLast = 3'(DataBits - 1);

  logic rx_s;

  uart_rx_sync #(
    .reset_value(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (in_serial_pin),
    .q    (rx_s)
  );

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            active_q, active_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;

    case (state_q)
      StIdle: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        if (!rx_s) begin
          state_d  = StStart;
          active_d = 1'b1;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = StData;
          end else begin
            // Start bit did not survive to mid-bit: treat as a glitch.
            state_d  = StIdle;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s == StopLevel) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = StClean;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StClean: begin
        active_d = 1'b0;
        state_d  = StIdle;
      end

      StBreak: begin
        // Wait out a held-low line so it cannot re-arm as a new start bit.
        if (rx_s) begin
          active_d = 1'b0;
          state_d  = StIdle;
        end
      end

      default: begin
        active_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  assign out_rx_byte       = byte_q;
  assign out_rx_data_valid = valid_q;
  assign out_rx_active     = active_q;
  assign out_framing_error = ferr_q;

endmodule
